op_dispatch_controller: RTL

Sequences the top-level operation modes: Matrix Input, Generate, Show, Calculate, Settings.
- Takes the decoded 3-bit op code from the switch decoder and a confirm button level.
- Requires op to be stable, then issues a one-cycle start pulse to exactly one mode sub-block and waits for that block's done.
- Reports busy, timeout and invalid/changed-op errors to the display/LED logic.

---
 rtl/op_dispatch_if.sv | 21 ++
 rtl/op_dispatch_controller.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/op_dispatch_if.sv
// Handshake bundle between the op dispatcher and the switch/LED/mode logic.
interface op_dispatch_if;
  logic [2:0] op;
  logic       confirm;
  logic [4:0] done;
  logic [4:0] start;
  logic [2:0] active_op;
  logic       busy;
  logic       err;
  logic [1:0] err_code;

  modport master (
    output op, confirm, done,
    input  start, active_op, busy, err, err_code
  );

  modport slave (
    input  op, confirm, done,
    output start, active_op, busy, err, err_code
  );
endinterface

// File: rtl/op_dispatch_controller.sv
// Top-level mode sequencer: waits for a stable op, pulses one start,
// then tracks done, timeout and op changes while the mode runs.
module op_dispatch_controller #(
  parameter int unsigned STABLE_CYCLES   = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 1000000,
  parameter int unsigned ERR_HOLD_CYCLES = 50000000
) (
  input logic          clk,
  input logic          rst,
  op_dispatch_if.slave bus
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int EW = (ERR_HOLD_CYCLES > 1) ? $clog2(ERR_HOLD_CYCLES) : 1;

  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [EW-1:0] ERR_LAST = EW'(ERR_HOLD_CYCLES - 1);
  localparam bit            TMO_EN   = (TIMEOUT_CYCLES != 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_DISP   = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_ERR    = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [SW-1:0] stab_q, stab_d;
  logic          confirm_q, confirm_d;
  logic [2:0]    act_q, act_d;
  logic [1:0]    code_q, code_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          chg_q, chg_d;
  logic [EW-1:0] ecnt_q, ecnt_d;

  logic       stable;
  logic       cedge;
  logic       op_ok;
  logic       op_diff;
  logic       done_hit;
  logic [4:0] sel;

  function automatic logic [4:0] op_sel(input logic [2:0] o);
    logic [4:0] r;
    case (o)
      3'd1:    r = 5'b00001;
      3'd2:    r = 5'b00010;
      3'd3:    r = 5'b00100;
      3'd4:    r = 5'b01000;
      3'd5:    r = 5'b10000;
      default: r = 5'b00000;
    endcase
    return r;
  endfunction

  assign stable   = (stab_q == STAB_MAX);
  assign cedge    = bus.confirm & ~confirm_q;
  assign op_ok    = (bus.op != 3'd0) && (bus.op <= 3'd5);
  assign op_diff  = (bus.op != act_q);
  assign sel      = op_sel(act_q);
  assign done_hit = |(bus.done & sel);

  always_comb begin
    state_d   = state_q;
    op_d      = bus.op;
    confirm_d = bus.confirm;
    act_d     = act_q;
    code_d    = code_q;
    tmo_d     = tmo_q;
    chg_d     = chg_q;
    ecnt_d    = ecnt_q;

    if (bus.op != op_q)
      stab_d = '0;
    else if (stable)
      stab_d = stab_q;
    else
      stab_d = stab_q + SW'(1);

    case (state_q)
      S_IDLE: begin
        if (cedge) begin
          state_d = S_SETTLE;
          code_d  = 2'd0;
        end
      end
      S_SETTLE: begin
        if (stable) begin
          if (op_ok) begin
            act_d   = bus.op;
            state_d = S_DISP;
          end else begin
            code_d  = 2'd1;
            ecnt_d  = '0;
            state_d = S_ERR;
          end
        end
      end
      S_DISP: begin
        tmo_d   = '0;
        chg_d   = 1'b0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        tmo_d = tmo_q + TW'(1);
        if (op_diff)
          chg_d = 1'b1;
        // done beats a same-cycle timeout
        if (done_hit) begin
          act_d = 3'd0;
          if (chg_q || op_diff) begin
            code_d  = 2'd3;
            ecnt_d  = '0;
            state_d = S_ERR;
          end else begin
            code_d  = 2'd0;
            state_d = S_IDLE;
          end
        end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
          act_d   = 3'd0;
          code_d  = 2'd2;
          ecnt_d  = '0;
          state_d = S_ERR;
        end
      end
      S_ERR: begin
        if (ecnt_q == ERR_LAST) begin
          act_d   = 3'd0;
          state_d = S_IDLE;
        end else begin
          ecnt_d = ecnt_q + EW'(1);
        end
      end
      default: begin
        act_d   = 3'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= 3'd0;
      stab_q    <= '0;
      confirm_q <= 1'b1;
      act_q     <= 3'd0;
      code_q    <= 2'd0;
      tmo_q     <= '0;
      chg_q     <= 1'b0;
      ecnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      stab_q    <= stab_d;
      confirm_q <= confirm_d;
      act_q     <= act_d;
      code_q    <= code_d;
      tmo_q     <= tmo_d;
      chg_q     <= chg_d;
      ecnt_q    <= ecnt_d;
    end
  end

  assign bus.start     = (state_q == S_DISP) ? sel : 5'b00000;
  assign bus.active_op = act_q;
  assign bus.busy      = (state_q == S_SETTLE) || (state_q == S_DISP) ||
                         (state_q == S_WAIT);
  assign bus.err       = (state_q == S_ERR);
  assign bus.err_code  = code_q;

endmodule
